uart_rx_os: RTL and testbench
=============================

// Module: uart_rx_os
// PURPOSE
//   Parametrised, oversampling UART receiver; successor to the fixed 8N1 receive path of uart_loop.
//   Configurable data width, parity, stop bits and oversampling; 3-sample majority vote per bit.
//   Delivers words on a valid/ready stream with per-word frame/parity flags and overrun reporting.
//   Sits between the pad synchroniser-free rx pin and loop/FIFO/TX logic in the UART designs.
// PARAMETERS
//   CLK_FREQ    10_000_000  system clock frequency in Hz
//   BAUD        9600        line rate in bit/s
//   OVERSAMPLE  16          ticks per bit; legal values 8 or 16
//   DATA_BITS   8           payload bits per frame, 5..9, LSB first
//   PARITY      0           0 = none, 1 = even, 2 = odd
//   STOP_BITS   1           1 or 2; every stop bit is checked
// PORTS
//   clk_i         in   1          system clock; all state on rising edge
//   rst_i         in   1          asynchronous, active-high reset
//   rx_i          in   1          asynchronous serial input, idle high
//   data_o        out  DATA_BITS  received word, valid while valid_o=1
//   valid_o       out  1          word available
//   ready_i       in   1          consumer accepts; transfer when valid_o & ready_i
//   frame_err_o   out  1          stop bit sampled 0; qualified by valid_o
//   parity_err_o  out  1          parity mismatch; qualified by valid_o; always 0 when PARITY=0
//   overrun_o     out  1          1-cycle pulse: completed word dropped, holding register full
// BEHAVIOUR
//   Reset: data_o=0, valid_o=0, frame_err_o=0, parity_err_o=0, overrun_o=0, FSM=IDLE,
//     synchroniser flops=1, tick counter=0. Reset mid-frame aborts the frame silently.
//   rx_i passes a 2-flop synchroniser; all decisions use the synchronised value.
//   Tick: DIV = round(CLK_FREQ/(BAUD*OVERSAMPLE)); 1-cycle tick every DIV clocks, free-running.
//   Sample index s counts ticks 0..OVERSAMPLE-1 within a bit; bit value = majority of samples at
//     s = OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1; bit decision taken at s = OVERSAMPLE/2+1.
//   FSM:
//     IDLE   -> START on synchronised rx = 0 (s cleared, aligned to that tick).
//     START  majority 1 -> IDLE (glitch, nothing reported); majority 0 -> DATA at s wrap.
//     DATA   shifts majority bit into bit DATA_BITS-1, shifting right (LSB first);
//            after DATA_BITS bits -> PARITY if PARITY!=0 else STOP.
//     PARITY compare majority with even/odd parity of the data bits; store mismatch -> STOP.
//     STOP   sample STOP_BITS stop bits; any 0 sets frame error. Word completes at the decision
//            sample of the last stop bit (no wait for bit end), then -> IDLE, or -> BREAK on frame error.
//     BREAK  wait until synchronised rx = 1, then -> IDLE (line held low is never re-read as data).
//   Output latency: valid_o rises the clock after the last stop-bit decision sample.
//   Holding register: on completion, if valid_o=0 or (valid_o & ready_i) same cycle, load data
//     and flags and hold valid_o=1 (no overrun); else drop the new word, keep old, pulse overrun_o.
//   valid_o, data_o and error flags stay stable until the transfer cycle; valid_o falls after it
//     unless a new word is loaded in the same cycle.
//   Frame/parity-errored words are still delivered; the consumer decides.
// STRUCTURE
//   Package uart_pkg: parity enum (PAR_NONE/EVEN/ODD), FSM state typedef,
//     function uart_div(clk, baud, os) for DIV, parameter legality checks.
//   Sub-module uart_baud_tick (counter producing the OVERSAMPLE tick); shared with a future TX.
//   Top holds synchroniser, FSM, shift register, majority vote, parity check, output register.
// TESTING (CLK_FREQ=10 MHz, BAUD=9600, OVERSAMPLE=16 -> DIV=65, unless noted)
//   8N1 frame 0xA5, ready_i=1 -> one valid_o beat, data_o=0xA5, both error flags 0.
//   PARITY=1, frame 0x3C with parity bit 1 -> data_o=0x3C, parity_err_o=1; parity bit 0 -> no error.
//   Stop bit 0 on 0x81, rx held low 3 frame times -> one beat 0x81 frame_err_o=1, no further
//     beats; then rx high and frame 0x55 -> data_o=0x55, no error.
//   3-clock low pulse on idle rx -> FSM returns to IDLE, valid_o never asserted.
//   ready_i=0, frames 0x11 then 0x22 -> data_o=0x11 held, one overrun_o pulse at 0x22 completion;
//     ready_i=1 -> single transfer of 0x11, valid_o falls next cycle.
//   rst_i pulsed during bit 3 of a frame -> outputs 0 immediately; following frame 0x0F received clean.
//   DATA_BITS=7, STOP_BITS=2, BAUD offset +/-2 %: 32 random words match, second stop bit 0 -> frame_err_o=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types, baud divisor helper and parameter legality check.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    // Rounded clocks per oversample tick.
    function automatic int unsigned uart_div(input int unsigned clk, input int unsigned baud,
                                             input int unsigned os);
        longint unsigned den;
        den = 64'(baud) * 64'(os);
        return 32'((64'(clk) + den / 64'(2)) / den);
    endfunction

    function automatic bit uart_params_ok(input int unsigned clk, input int unsigned baud,
                                          input int unsigned os, input int unsigned data_bits,
                                          input int unsigned parity, input int unsigned stop_bits);
        return (os == 8 || os == 16) && (data_bits >= 5) && (data_bits <= 9) &&
               (parity <= 2) && (stop_bits == 1 || stop_bits == 2) &&
               (baud != 0) && (uart_div(clk, baud, os) >= 1);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
module uart_baud_tick #(
    parameter int unsigned DIV = 65
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_o <= 1'b0;
        end else if (cnt_q == CW'(DIV - 1)) begin
            cnt_q  <= '0;
            tick_o <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + CW'(1);
            tick_o <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority vote, parity/frame checks and a
// valid/ready holding register that reports overrun when a word is dropped.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 10_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o
);

    localparam int unsigned DIV      = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned SW       = $clog2(OVERSAMPLE);
    localparam int unsigned HALF     = OVERSAMPLE / 2;
    localparam int unsigned BCW      = 4;
    localparam parity_e     PAR_MODE = parity_e'(2'(PARITY));

    if (!uart_params_ok(CLK_FREQ, BAUD, OVERSAMPLE, DATA_BITS, PARITY, STOP_BITS)) begin : g_bad_params
        $error("uart_rx_os: illegal parameter combination");
    end

    logic [1:0]           sync_q;
    logic                 rx_s;
    logic                 tick;
    rx_state_e            state_q, state_d;
    logic [SW-1:0]        s_q;
    logic [1:0]           samp_q;
    logic [BCW-1:0]       bit_cnt_q;
    logic                 stop_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_q, frm_err_q;
    logic                 maj_c, decide_c, wrap_c, done_c, frm_now_c, exp_par_c;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], rx_i};
    end
    assign rx_s = sync_q[1];

    assign maj_c     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign decide_c  = tick && (s_q == SW'(HALF + 1));
    assign wrap_c    = tick && (s_q == SW'(OVERSAMPLE - 1));
    assign frm_now_c = frm_err_q | ~maj_c;
    assign exp_par_c = (PAR_MODE == PAR_ODD) ? ~(^shift_q) : ^shift_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        done_c  = 1'b0;
        unique case (state_q)
            ST_IDLE:   if (tick && !rx_s) state_d = ST_START;
            ST_START: begin
                if (decide_c && maj_c) state_d = ST_IDLE;
                else if (wrap_c)       state_d = ST_DATA;
            end
            ST_DATA: begin
                if (wrap_c && bit_cnt_q == BCW'(DATA_BITS - 1))
                    state_d = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (wrap_c) state_d = ST_STOP;
            ST_STOP: begin
                // Word completes at the last stop-bit decision, not at bit end.
                if (decide_c && stop_cnt_q == 1'(STOP_BITS - 1)) begin
                    done_c  = 1'b1;
                    state_d = frm_now_c ? ST_BREAK : ST_IDLE;
                end
            end
            ST_BREAK:  if (rx_s) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Sample counter, vote samples, shift register and per-frame error state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_q        <= '0;
            samp_q     <= 2'b11;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else if (state_q == ST_IDLE || state_q == ST_BREAK) begin
            s_q        <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            if (tick) begin
                s_q <= (s_q == SW'(OVERSAMPLE - 1)) ? '0 : s_q + SW'(1);
                if (s_q == SW'(HALF - 1)) samp_q[0] <= rx_s;
                if (s_q == SW'(HALF))     samp_q[1] <= rx_s;
            end
            if (wrap_c && state_q == ST_DATA) bit_cnt_q  <= bit_cnt_q + BCW'(1);
            if (wrap_c && state_q == ST_STOP) stop_cnt_q <= 1'b1;
            if (decide_c && state_q == ST_DATA)
                shift_q <= {maj_c, shift_q[DATA_BITS-1:1]};
            if (decide_c && state_q == ST_PARITY) par_err_q <= maj_c ^ exp_par_c;
            if (decide_c && state_q == ST_STOP && !maj_c) frm_err_q <= 1'b1;
        end
    end

    // Holding register: accept a new word only if empty or draining this cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o       <= '0;
            valid_o      <= 1'b0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (done_c) begin
                if (!valid_o || ready_i) begin
                    data_o       <= shift_q;
                    frame_err_o  <= frm_now_c;
                    parity_err_o <= par_err_q;
                    valid_o      <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: four instances (spec-rate 8N1, fast 8N1, fast 8E1, fast 7N2).
`timescale 1ns/1ps
module tb_uart_rx_os;
    import uart_pkg::*;

    localparam int SPEC_BIT_NS = 104167;
    localparam int FAST_BIT_NS = 6400;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #50 clk = ~clk;

    logic       rx_a, ready_a, valid_a, fe_a, pe_a, ovr_a;
    logic [7:0] data_a;
    logic       rx_n, ready_n, valid_n, fe_n, pe_n, ovr_n;
    logic [7:0] data_n;
    logic       rx_p, ready_p, valid_p, fe_p, pe_p, ovr_p;
    logic [7:0] data_p;
    logic       rx_w, ready_w, valid_w, fe_w, pe_w, ovr_w;
    logic [6:0] data_w;

    uart_rx_os #(.CLK_FREQ(10_000_000), .BAUD(9600), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_spec (
        .clk_i(clk), .rst_i(rst), .rx_i(rx_a), .data_o(data_a), .valid_o(valid_a),
        .ready_i(ready_a), .frame_err_o(fe_a), .parity_err_o(pe_a), .overrun_o(ovr_a));

    uart_rx_os #(.CLK_FREQ(10_000_000), .BAUD(156250), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n (
        .clk_i(clk), .rst_i(rst), .rx_i(rx_n), .data_o(data_n), .valid_o(valid_n),
        .ready_i(ready_n), .frame_err_o(fe_n), .parity_err_o(pe_n), .overrun_o(ovr_n));

    uart_rx_os #(.CLK_FREQ(10_000_000), .BAUD(156250), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_p (
        .clk_i(clk), .rst_i(rst), .rx_i(rx_p), .data_o(data_p), .valid_o(valid_p),
        .ready_i(ready_p), .frame_err_o(fe_p), .parity_err_o(pe_p), .overrun_o(ovr_p));

    uart_rx_os #(.CLK_FREQ(10_000_000), .BAUD(156250), .OVERSAMPLE(16),
                 .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7 (
        .clk_i(clk), .rst_i(rst), .rx_i(rx_w), .data_o(data_w), .valid_o(valid_w),
        .ready_i(ready_w), .frame_err_o(fe_w), .parity_err_o(pe_w), .overrun_o(ovr_w));

    logic [10:0] q_a[$], q_n[$], q_p[$], q_w[$];
    int          ovr_cnt_n, vcnt_n;
    int          n_checks, n_pass, n_fail;

    // Record every handshake beat as {frame_err, parity_err, data}.
    always @(negedge clk) begin
        if (valid_a && ready_a) q_a.push_back({fe_a, pe_a, 1'b0, data_a});
        if (valid_n && ready_n) q_n.push_back({fe_n, pe_n, 1'b0, data_n});
        if (valid_p && ready_p) q_p.push_back({fe_p, pe_p, 1'b0, data_p});
        if (valid_w && ready_w) q_w.push_back({fe_w, pe_w, 2'b00, data_w});
        if (ovr_n)   ovr_cnt_n++;
        if (valid_n) vcnt_n++;
    end

    function automatic logic [10:0] mk(input logic fe, input logic pe, input logic [8:0] d);
        return {fe, pe, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int which, input logic v);
        case (which)
            0:       rx_a = v;
            1:       rx_n = v;
            2:       rx_p = v;
            default: rx_w = v;
        endcase
    endtask

    task automatic pop(input int which, output logic [10:0] w);
        w = 11'h7FF;
        case (which)
            0:       if (q_a.size() > 0) w = q_a.pop_front();
            1:       if (q_n.size() > 0) w = q_n.pop_front();
            2:       if (q_p.size() > 0) w = q_p.pop_front();
            default: if (q_w.size() > 0) w = q_w.pop_front();
        endcase
    endtask

    // Drives start, data (LSB first), optional parity (pbit<0: none) and stop bits; leaves line at last stop level.
    task automatic send_frame(input int which, input logic [8:0] d, input int nb, input int pbit,
                              input int nstop, input logic st0, input logic st1, input int bit_ns);
        set_rx(which, 1'b0);
        #(bit_ns);
        for (int i = 0; i < nb; i++) begin
            set_rx(which, d[i]);
            #(bit_ns);
        end
        if (pbit >= 0) begin
            set_rx(which, pbit[0]);
            #(bit_ns);
        end
        set_rx(which, st0);
        #(bit_ns);
        if (nstop == 2) begin
            set_rx(which, st1);
            #(bit_ns);
        end
    endtask

    initial begin
        #20ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [10:0] w;
        logic [6:0]  ex[32];
        int          ov0, vc0, bns;
        n_checks = 0; n_pass = 0; n_fail = 0;
        ovr_cnt_n = 0; vcnt_n = 0;
        rst = 1'b1;
        rx_a = 1'b1; rx_n = 1'b1; rx_p = 1'b1; rx_w = 1'b1;
        ready_a = 1'b1; ready_n = 1'b1; ready_p = 1'b1; ready_w = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(3);

        chk("rst_data",    32'(data_n), 32'h0);
        chk("rst_valid",   32'(valid_n), 32'h0);
        chk("rst_frame",   32'(fe_n), 32'h0);
        chk("rst_parity",  32'(pe_n), 32'h0);
        chk("rst_overrun", 32'(ovr_n), 32'h0);
        chk("div_spec",    32'(uart_div(10_000_000, 9600, 16)), 32'd65);

        // Spec-rate 8N1 frame 0xA5
        send_frame(0, 9'h0A5, 8, -1, 1, 1'b1, 1'b1, SPEC_BIT_NS);
        set_rx(0, 1'b1);
        #(SPEC_BIT_NS);
        chk("a5_beats", 32'(q_a.size()), 32'd1);
        pop(0, w);
        chk("a5_word", 32'(w), 32'(mk(1'b0, 1'b0, 9'h0A5)));

        // Even parity: 0x3C has four ones, so a parity bit of 1 is wrong
        send_frame(2, 9'h03C, 8, 1, 1, 1'b1, 1'b1, FAST_BIT_NS);
        set_rx(2, 1'b1);
        #(FAST_BIT_NS);
        send_frame(2, 9'h03C, 8, 0, 1, 1'b1, 1'b1, FAST_BIT_NS);
        set_rx(2, 1'b1);
        #(FAST_BIT_NS);
        chk("par_beats", 32'(q_p.size()), 32'd2);
        pop(2, w);
        chk("par_bad_word", 32'(w), 32'(mk(1'b0, 1'b1, 9'h03C)));
        pop(2, w);
        chk("par_ok_word", 32'(w), 32'(mk(1'b0, 1'b0, 9'h03C)));

        // Stop bit 0 then line held low for three frame times
        send_frame(1, 9'h081, 8, -1, 1, 1'b0, 1'b0, FAST_BIT_NS);
        #(30 * FAST_BIT_NS);
        chk("brk_beats", 32'(q_n.size()), 32'd1);
        pop(1, w);
        chk("brk_word", 32'(w), 32'(mk(1'b1, 1'b0, 9'h081)));
        set_rx(1, 1'b1);
        #(2 * FAST_BIT_NS);
        send_frame(1, 9'h055, 8, -1, 1, 1'b1, 1'b1, FAST_BIT_NS);
        set_rx(1, 1'b1);
        #(2 * FAST_BIT_NS);
        chk("post_brk_beats", 32'(q_n.size()), 32'd1);
        pop(1, w);
        chk("post_brk_word", 32'(w), 32'(mk(1'b0, 1'b0, 9'h055)));

        // Three-clock glitch on idle line
        vc0 = vcnt_n;
        wait_clk(1);
        rx_n = 1'b0;
        wait_clk(3);
        rx_n = 1'b1;
        #(3 * FAST_BIT_NS);
        chk("glitch_valid", 32'(vcnt_n - vc0), 32'd0);
        chk("glitch_beats", 32'(q_n.size()), 32'd0);
        chk("glitch_state", 32'(u_n.state_q), 32'(ST_IDLE));

        // Overrun: consumer stalled across two frames
        wait_clk(1);
        ready_n = 1'b0;
        ov0 = ovr_cnt_n;
        send_frame(1, 9'h011, 8, -1, 1, 1'b1, 1'b1, FAST_BIT_NS);
        set_rx(1, 1'b1);
        #(FAST_BIT_NS);
        send_frame(1, 9'h022, 8, -1, 1, 1'b1, 1'b1, FAST_BIT_NS);
        set_rx(1, 1'b1);
        #(FAST_BIT_NS);
        wait_clk(1);
        chk("ovr_valid",  32'(valid_n), 32'h1);
        chk("ovr_data",   32'(data_n), 32'h11);
        chk("ovr_pulses", 32'(ovr_cnt_n - ov0), 32'd1);
        ready_n = 1'b1;
        wait_clk(1);
        chk("ovr_valid_fall", 32'(valid_n), 32'h0);
        wait_clk(2);
        chk("ovr_beats", 32'(q_n.size()), 32'd1);
        pop(1, w);
        chk("ovr_word", 32'(w), 32'(mk(1'b0, 1'b0, 9'h011)));

        // Reset during bit 3 of a frame
        set_rx(1, 1'b0);
        #(FAST_BIT_NS);
        set_rx(1, 1'b1);
        #(3 * FAST_BIT_NS + FAST_BIT_NS / 2);
        wait_clk(0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_data",  32'(data_n), 32'h0);
        chk("midrst_valid", 32'(valid_n), 32'h0);
        chk("midrst_state", 32'(u_n.state_q), 32'(ST_IDLE));
        wait_clk(2);
        rst = 1'b0;
        #(12 * FAST_BIT_NS);
        send_frame(1, 9'h00F, 8, -1, 1, 1'b1, 1'b1, FAST_BIT_NS);
        set_rx(1, 1'b1);
        #(2 * FAST_BIT_NS);
        chk("midrst_beats", 32'(q_n.size()), 32'd1);
        pop(1, w);
        chk("midrst_word", 32'(w), 32'(mk(1'b0, 1'b0, 9'h00F)));

        // 7N2 with +/-2 % line-rate offset
        for (int i = 0; i < 32; i++) begin
            ex[i] = 7'($urandom_range(0, 127));
            bns = (i % 2 == 1) ? 6528 : 6272;
            send_frame(3, {2'b00, ex[i]}, 7, -1, 2, 1'b1, 1'b1, bns);
            set_rx(3, 1'b1);
            #(bns);
        end
        #(FAST_BIT_NS);
        chk("w7_beats", 32'(q_w.size()), 32'd32);
        for (int i = 0; i < 32; i++) begin
            pop(3, w);
            chk($sformatf("w7_word_%0d", i), 32'(w), 32'(mk(1'b0, 1'b0, {2'b00, ex[i]})));
        end
        send_frame(3, 9'h05A, 7, -1, 2, 1'b1, 1'b0, FAST_BIT_NS);
        set_rx(3, 1'b1);
        #(2 * FAST_BIT_NS);
        chk("w7_stop2_beats", 32'(q_w.size()), 32'd1);
        pop(3, w);
        chk("w7_stop2_word", 32'(w), 32'(mk(1'b1, 1'b0, 9'h05A)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
